// File: rtl/fdc_sd_arbiter_pkg.sv
// Shared definitions for the floppy SD-block arbiter slice.
//   arb_state_e : arbiter state encoding (IDLE, REQ, XFER)
//   N_PORTS_DEF : default number of drive channels
//   GRANT_W     : grant index width for the default channel count
//   grant_w()   : grant index width for an arbitrary channel count
package coco_sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam int unsigned N_PORTS_DEF = 4;
  localparam int unsigned GRANT_W     = $clog2(N_PORTS_DEF);

  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fdc_sd_arbiter_if.sv
// Bus bundle between the per-drive wd1793 SD channels and the hps_io SD port.
//   fdc_lba/fdc_rd/fdc_wr/fdc_buff_din : per-drive request side (into arbiter)
//   fdc_ack                            : per-drive acknowledge (from arbiter)
//   sd_lba/sd_rd/sd_wr/sd_buff_din     : merged request toward hps_io
//   sd_ack                             : acknowledge from hps_io
// modport master : arbiter view; modport slave : drives + host view.
interface fdc_sd_arbiter_if
  import coco_sd_pkg::*;
#(
  parameter int unsigned N_PORTS = N_PORTS_DEF
) ();

  logic [N_PORTS-1:0][31:0] fdc_lba;
  logic [N_PORTS-1:0]       fdc_rd;
  logic [N_PORTS-1:0]       fdc_wr;
  logic [N_PORTS-1:0]       fdc_ack;
  logic [N_PORTS-1:0][7:0]  fdc_buff_din;
  logic [31:0]              sd_lba;
  logic                     sd_rd;
  logic                     sd_wr;
  logic                     sd_ack;
  logic [7:0]               sd_buff_din;

  modport master (
    input  fdc_lba, fdc_rd, fdc_wr, fdc_buff_din, sd_ack,
    output fdc_ack, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

  modport slave (
    output fdc_lba, fdc_rd, fdc_wr, fdc_buff_din, sd_ack,
    input  fdc_ack, sd_lba, sd_rd, sd_wr, sd_buff_din
  );

endinterface

// File: rtl/fdc_sd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   pend_i  : per-drive pending request vector
//   last_i  : index of the drive served last
//   valid_o : at least one request pending
//   idx_o   : first pending index scanning from last_i+1 (mod N_PORTS)
module rr_pick
  import coco_sd_pkg::*;
#(
  parameter  int unsigned N_PORTS = N_PORTS_DEF,
  localparam int unsigned GW      = grant_w(N_PORTS)
) (
  input  logic [N_PORTS-1:0] pend_i,
  input  logic [GW-1:0]      last_i,
  output logic               valid_o,
  output logic [GW-1:0]      idx_o
);

  logic [GW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand = GW'((32'(last_i) + k) % N_PORTS);
      if (!valid_o && pend_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Merges N_PORTS wd1793 SD block-request channels onto the single hps_io SD
// port. One request is forwarded at a time, picked round-robin; ack and
// buffer-read data are routed back to the granted drive only.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : drive/host bundle (master modport)
//   grant        : index of current or last granted drive
//   busy         : arbiter not idle
//   timeout_err  : sticky, set when a request is never acknowledged
module fdc_sd_arbiter
  import coco_sd_pkg::*;
#(
  parameter  int unsigned N_PORTS = N_PORTS_DEF,
  parameter  int unsigned TO_BITS = 24,
  localparam int unsigned GW      = grant_w(N_PORTS)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  fdc_sd_arbiter_if.master     bus,
  output logic [GW-1:0]        grant,
  output logic                 busy,
  output logic                 timeout_err
);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        lba_q, lba_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [TO_BITS-1:0] wd_q, wd_d;
  logic               busy_q, busy_d;
  logic               to_q, to_d;

  logic [N_PORTS-1:0] pend;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;
  logic               g_req;
  logic [TO_BITS-1:0] wd_inc;

  assign pend   = bus.fdc_rd | bus.fdc_wr;
  assign g_req  = bus.fdc_rd[grant_q] | bus.fdc_wr[grant_q];
  assign wd_inc = wd_q + 1'b1;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .pend_i  (pend),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          lba_d   = bus.fdc_lba[pick_idx];
          // read wins when both are raised; the write stays pending
          rd_d    = bus.fdc_rd[pick_idx];
          wr_d    = ~bus.fdc_rd[pick_idx];
          wd_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (!g_req) begin
          // cancelled by the drive: keep priority order unchanged
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if (&wd_inc) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          to_d    = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      XFER: begin
        if (!bus.sd_ack) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q  <= GW'(N_PORTS - 1);
      grant_q <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
    end
  end

  // Zero-latency return path, gated to the granted drive only.
  always_comb begin
    bus.fdc_ack     = '0;
    bus.sd_buff_din = '0;
    if (state_q != IDLE) bus.fdc_ack[grant_q] = bus.sd_ack;
    if (state_q == XFER) bus.sd_buff_din = bus.fdc_buff_din[grant_q];
  end

  assign bus.sd_lba   = lba_q;
  assign bus.sd_rd    = rd_q;
  assign bus.sd_wr    = wr_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign timeout_err  = to_q;

endmodule

// File: doc/fdc_sd_arbiter.md
# fdc_sd_arbiter

Merges the four per-drive SD block-request channels produced by the floppy controller (one wd1793 per drive) onto the single MiSTer hps_io SD block port. It arbitrates round-robin, forwards one request at a time to the host, and routes the host acknowledge and buffer-read data back to the granted drive only. It sits directly downstream of the floppy controller and upstream of hps_io.

## Interface

Parameters:
- N_PORTS, default 4: number of drive channels. The block is verified at 4.
- TO_BITS, default 24: width of the request watchdog counter. Timeout is reached when the counter is all ones.

Ports:
- CLK, in, 1: system clock. The block uses one clock.
- RESET_N, in, 1: reset, asynchronous and active-low.
- fdc_lba, in, 32×N_PORTS: per-drive LBA (fdc sd_lba[i]).
- fdc_rd, in, N_PORTS: per-drive read request, level.
- fdc_wr, in, N_PORTS: per-drive write request, level.
- fdc_ack, out, N_PORTS: per-drive acknowledge.
- fdc_buff_din, in, 8×N_PORTS: per-drive buffer data toward the host.
- sd_lba, out, 32: LBA to hps_io.
- sd_rd, out, 1: read request to hps_io.
- sd_wr, out, 1: write request to hps_io.
- sd_ack, in, 1: acknowledge from hps_io.
- sd_buff_din, out, 8: buffer data to hps_io.
- grant, out, 2: index of the current or last granted drive.
- busy, out, 1: high in any state other than IDLE.
- timeout_err, out, 1: sticky. Set on watchdog expiry, cleared only by reset.

## Operation

State machine: IDLE, REQ, XFER.

IDLE:
- pend[i] = fdc_rd[i] | fdc_wr[i].
- If any pend is set, pick the first set index scanning from last+1 modulo N_PORTS.
- Latch g, the LBA and the operation. If rd and wr are both set, rd wins; the wr is served on a later grant.
- Go to REQ. Clear the watchdog.

REQ:
- sd_rd or sd_wr is held high and sd_lba = latched LBA.
- sd_ack=1: drop sd_rd/sd_wr and go to XFER.
- Granted drive drops both of its request lines while sd_ack=0: cancel and return to IDLE. last is not updated.
- Watchdog reaches all ones: set timeout_err, drop the request, return to IDLE, and set last=g so the next drive gets priority.

XFER:
- Wait for sd_ack=0, then go to IDLE and set last=g.

Routing (combinational, zero latency):
- fdc_ack[g] = sd_ack in REQ or XFER. All other fdc_ack bits are 0.
- sd_buff_din = fdc_buff_din[g] in XFER, else 0.
- sd_buff_addr, sd_buff_dout and sd_buff_wr are not routed here. They fan out to all drives unchanged; isolation relies on ack gating inside each wd1793.

New requests from other drives during REQ/XFER are ignored until IDLE. The latched LBA does not follow later changes on fdc_lba.

## Timing

- Reset values: sd_rd=0, sd_wr=0, sd_lba=0, sd_buff_din=0, fdc_ack=0, grant=0, busy=0, timeout_err=0, last=N_PORTS-1 (so drive 0 has first priority), state=IDLE.
- sd_rd, sd_wr, sd_lba, grant and busy are registered.
- Request sampled high in IDLE at cycle N: sd_rd/sd_wr=1 and busy=1 at N+1.
- sd_ack rises at cycle M: fdc_ack[g]=1 at M (combinational); sd_rd/sd_wr=0 at M+1.
- sd_ack falls at cycle K: fdc_ack[g]=0 at K; IDLE at K+1; next grant's request at K+2 at the earliest.
- Watchdog: counts CLK cycles in REQ. With TO_BITS=24, expiry occurs 2^24-1 cycles after entering REQ.
- RESET_N asserted mid-transfer: all outputs take reset values immediately (async). No request is reissued after release.

## Structure

- Shared package coco_sd_pkg holds:
  - the state enum (IDLE, REQ, XFER);
  - N_PORTS_DEF;
  - the grant index width, $clog2(N_PORTS).
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs: pend vector and last. Outputs: valid and index.
- The FSM, latches and watchdog live in fdc_sd_arbiter.

## Test plan

- Single read: fdc_rd[2]=1, fdc_lba[2]=0x123 → sd_rd=1, sd_lba=0x123 one cycle later; sd_ack pulse of 10 cycles → fdc_ack[2] mirrors it exactly, fdc_ack[0,1,3]=0, sd_rd drops the cycle after ack rises.
- Round-robin: drives 0, 1 and 3 request simultaneously from reset → grants occur in order 0, 1, 3. Drive 0 re-requests immediately after its transfer → it is served after 3.
- Write data path: fdc_wr[1]=1, fdc_buff_din[1]=0xA5, fdc_buff_din[0]=0x5A → sd_wr=1; sd_buff_din=0xA5 during XFER and 0x00 in IDLE.
- rd+wr both set on drive 3 → read served first; after it completes, with wr still held, a write to the same drive is issued.
- Timeout with TO_BITS=4: request issued, no ack → after 15 cycles sd_rd=0, timeout_err=1, state IDLE. A pending request from drive 0 is then granted.
- Reset during XFER: RESET_N low while sd_ack=1 → fdc_ack, sd_rd and busy go to 0 immediately; after release no request is issued until a new fdc_rd is presented.
